seg_scan_ctrl: RTL and testbench

- Four-digit seven-segment display scan controller. It time-multiplexes one shared, active-low segment bus across four common-anode digits.
- Display contents (hex nibbles, per-digit enable, decimal points) are loaded through a valid/ready handshake into a shadow register. The shadow register is applied atomically at frame boundaries, so a frame never mixes old and new data.
- Sits between upstream value producers (e.g. priority encoder result, counters) and the board's segments/anodes pins.

---
 rtl/seg_scan_pkg.sv | 18 +
 rtl/hex7seg_dec.sv | 11 +
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_scan_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'hF;

   localparam logic [6:0] HEX7_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex7seg_dec
   import seg_scan_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   assign o_seg = HEX7_TBL[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with a shadow register that is
// applied only at frame boundaries, so a frame never mixes old and new data.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int CNT_W        = 16
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_scan_en,
   input  logic        i_load_valid,
   output logic        o_load_ready,
   input  logic [15:0] i_load_hex,
   input  logic [3:0]  i_load_den,
   input  logic [3:0]  i_load_dp,
   output logic [3:0]  o_anodes,
   output logic [7:0]  o_segments,
   output logic        o_frame_done
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_idx;
   logic [15:0]       r_act_hex, r_sh_hex;
   logic [3:0]        r_act_den, r_sh_den;
   logic [3:0]        r_act_dp,  r_sh_dp;
   logic              r_pending;
   logic              r_load_ready;
   logic [3:0]        r_anodes;
   logic [7:0]        r_segments;
   logic              r_frame_done;

   state_t            w_state_next;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [1:0]        w_idx_next;
   logic              w_boundary;
   logic              w_load_fire;
   logic              w_lit;
   logic [3:0]        w_nib;
   logic [6:0]        w_seg7;
   logic [3:0]        w_an_next;
   logic [7:0]        w_seg_next;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt + CNT_W'(1);
      w_idx_next   = r_idx;
      w_boundary   = 1'b0;
      if (!i_scan_en) begin
         w_state_next = BLANK;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_state_next = SHOW;
                  w_cnt_next   = '0;
               end
            end
            SHOW: begin
               if (r_cnt == DWELL_LAST) begin
                  w_state_next = BLANK;
                  w_cnt_next   = '0;
                  w_idx_next   = r_idx + 2'd1;
                  w_boundary   = (r_idx == 2'd3);
               end
            end
            default: begin
               w_state_next = BLANK;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   // Outputs are computed from the next state so the first SHOW cycle is lit.
   assign w_lit      = (w_state_next == SHOW) && r_act_den[w_idx_next];
   assign w_nib      = r_act_hex[{w_idx_next, 2'b00} +: 4];
   assign w_an_next  = w_lit ? ~(4'b0001 << w_idx_next) : AN_OFF;
   assign w_seg_next = w_lit ? {~r_act_dp[w_idx_next], w_seg7} : SEG_OFF;
   assign w_load_fire = i_load_valid & ~r_pending;

   hex7seg_dec u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg7)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= BLANK;
         r_cnt        <= '0;
         r_idx        <= 2'd0;
         r_act_hex    <= '0;
         r_act_den    <= '0;
         r_act_dp     <= '0;
         r_sh_hex     <= '0;
         r_sh_den     <= '0;
         r_sh_dp      <= '0;
         r_pending    <= 1'b0;
         r_load_ready <= 1'b1;
         r_anodes     <= AN_OFF;
         r_segments   <= SEG_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_idx        <= w_idx_next;
         r_anodes     <= w_an_next;
         r_segments   <= w_seg_next;
         r_frame_done <= w_boundary;
         // A pending load blocks new transfers, so apply and capture never collide.
         if (w_boundary && r_pending) begin
            r_act_hex    <= r_sh_hex;
            r_act_den    <= r_sh_den;
            r_act_dp     <= r_sh_dp;
            r_pending    <= 1'b0;
            r_load_ready <= 1'b1;
         end else if (w_load_fire) begin
            r_sh_hex     <= i_load_hex;
            r_sh_den     <= i_load_den;
            r_sh_dp      <= i_load_dp;
            r_pending    <= 1'b1;
            r_load_ready <= 1'b0;
         end
      end
   end

   assign o_load_ready = r_load_ready;
   assign o_anodes     = r_anodes;
   assign o_segments   = r_segments;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a slot/phase reference model.
module tb_seg_scan_ctrl;

   localparam int DW   = 4;
   localparam int BL   = 2;
   localparam int SLOT = DW + BL;
   localparam bit [6:0] TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        scan_en = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_hex = '0;
   logic [3:0]  load_den = '0;
   logic [3:0]  load_dp = '0;
   logic        load_ready;
   logic [3:0]  anodes;
   logic [7:0]  segments;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // reference model: position within the current slot and digit being scanned
   int          m_ph, m_idx, m_accepts;
   bit          m_pend;
   logic [15:0] m_ahex, m_shex;
   logic [3:0]  m_aden, m_adp, m_sden, m_sdp;
   logic [3:0]  e_an;
   logic [7:0]  e_seg;
   logic        e_fd, e_ready;

   seg_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .CNT_W(16)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_scan_en    (scan_en),
      .i_load_valid (load_valid),
      .o_load_ready (load_ready),
      .i_load_hex   (load_hex),
      .i_load_den   (load_den),
      .i_load_dp    (load_dp),
      .o_anodes     (anodes),
      .o_segments   (segments),
      .o_frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_idx = 0; m_pend = 0;
      m_ahex = '0; m_aden = '0; m_adp = '0;
      m_shex = '0; m_sden = '0; m_sdp = '0;
      e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0; e_ready = 1'b1;
   endtask

   task automatic model_step();
      bit bnd;
      bnd = scan_en && (m_idx == 3) && (m_ph == SLOT - 1);
      if (!scan_en) m_ph = 0;
      else if (m_ph == SLOT - 1) begin
         m_ph  = 0;
         m_idx = (m_idx + 1) % 4;
      end else m_ph++;
      if (bnd && m_pend) begin
         m_ahex = m_shex; m_aden = m_sden; m_adp = m_sdp;
         m_pend = 0;
      end else if (load_valid && !m_pend) begin
         m_shex = load_hex; m_sden = load_den; m_sdp = load_dp;
         m_pend = 1;
         m_accepts++;
      end
      e_fd    = bnd;
      e_ready = !m_pend;
      if (scan_en && m_ph >= BL && m_aden[m_idx]) begin
         e_an  = 4'hF ^ (4'(1) << m_idx);
         e_seg = {~m_adp[m_idx], TBL[m_ahex[4*m_idx +: 4]]};
      end else begin
         e_an  = 4'hF;
         e_seg = 8'hFF;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("anodes", 32'(anodes), 32'(e_an));
      check("segments", 32'(segments), 32'(e_seg));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      check("load_ready", 32'(load_ready), 32'(e_ready));
   endtask

   task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] p);
      int start;
      bit ok;
      start = m_accepts;
      ok = 0;
      load_valid = 1'b1; load_hex = h; load_den = d; load_dp = p;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (m_accepts != start) begin
            ok = 1;
            break;
         end
      end
      load_valid = 1'b0;
      check("load_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_show(input int n);
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (scan_en && m_ph >= BL && m_idx == n) begin
            ok = 1;
            break;
         end
      end
      check("wait_show", 32'(ok), 32'd1);
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      check("rst_anodes", 32'(anodes), 32'hF);
      check("rst_segments", 32'(segments), 32'hFF);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int acc0;
      m_accepts = 0;
      model_reset();
      #2;
      async_reset();
      scan_en = 1'b1;

      // idle after reset: dark, frame_done every 24 cycles
      repeat (48) tick();

      // single load, shown from the frame after the next boundary
      do_load(16'h3A81, 4'b1111, 4'b0010);
      repeat (60) tick();

      // back-to-back loads with valid held high
      acc0 = m_accepts;
      load_valid = 1'b1; load_hex = 16'h1234; load_den = 4'hF; load_dp = 4'h0;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (m_accepts == acc0 + 1) begin
            load_hex = 16'hBEEF; load_dp = 4'hF;
         end
         if (m_accepts >= acc0 + 2) break;
      end
      load_valid = 1'b0;
      check("b2b_accepts", 32'(m_accepts - acc0), 32'd2);
      repeat (60) tick();

      // sparse digit enables
      do_load(16'hFFFF, 4'b0101, 4'b0000);
      repeat (60) tick();

      // scan_en drop during digit 2
      wait_show(2);
      scan_en = 1'b0;
      repeat (5) tick();
      scan_en = 1'b1;
      repeat (30) tick();

      // reset mid-SHOW, then dark until a new load lands
      do_load(16'h3A81, 4'b1111, 4'b0010);
      repeat (30) tick();
      wait_show(1);
      async_reset();
      repeat (60) tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         scan_en = ($urandom_range(0, 19) != 0);
         if (!(load_valid && !e_ready)) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_hex   = 16'($urandom);
            load_den   = 4'($urandom);
            load_dp    = 4'($urandom);
         end
         if ($urandom_range(0, 599) == 0) begin
            load_valid = 1'b0;
            async_reset();
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
